// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with single-beat 256-bit line fill
// from physical memory, whole-cache invalidate and hit/miss counters.
module icache #(
    parameter int unsigned S_INDEX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  imem_address,
    input  logic         imem_read,
    output logic [31:0]  imem_rdata,
    output logic         imem_resp,
    input  logic         inv,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
);
    localparam int unsigned SETS = 1 << S_INDEX;
    localparam int unsigned T    = 27 - S_INDEX;

    typedef enum logic {
        COMPARE,
        FILL
    } state_e;

    state_e              state_q, state_d;
    logic                req_valid_q, req_valid_d;
    logic [31:2]         req_addr_q, req_addr_d;
    logic [SETS-1:0]     valid_q, valid_d;
    logic [T-1:0]        tag_q  [SETS];
    logic [255:0]        line_q [SETS];
    logic [31:0]         hit_count_q, hit_count_d;
    logic [31:0]         miss_count_q, miss_count_d;

    logic [T-1:0]        req_tag;
    logic [S_INDEX-1:0]  req_idx;
    logic [2:0]          req_word;
    logic                hit;
    logic                fill_done;
    logic                unused_byte_offset;

    assign req_tag            = req_addr_q[31:5+S_INDEX];
    assign req_idx            = req_addr_q[4+S_INDEX:5];
    assign req_word           = req_addr_q[4:2];
    assign unused_byte_offset = ^imem_address[1:0];

    always_comb begin
        state_d      = state_q;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        valid_d      = valid_q;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        hit          = 1'b0;
        fill_done    = 1'b0;
        imem_resp    = 1'b0;
        imem_rdata   = '0;
        pmem_read    = 1'b0;
        pmem_address = '0;

        unique case (state_q)
            COMPARE: begin
                hit = req_valid_q && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
                if (hit) begin
                    imem_resp   = 1'b1;
                    imem_rdata  = line_q[req_idx][32*req_word +: 32];
                    hit_count_d = hit_count_q + 32'd1;
                end else if (req_valid_q) begin
                    state_d      = FILL;
                    miss_count_d = miss_count_q + 32'd1;
                end
                // The request register only advances once the held request is served.
                if (!req_valid_q || hit) begin
                    req_valid_d = imem_read;
                    req_addr_d  = imem_address[31:2];
                end
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {req_addr_q[31:5], 5'b0};
                if (pmem_resp) begin
                    fill_done = 1'b1;
                    state_d   = COMPARE;
                end
            end
            default: state_d = COMPARE;
        endcase

        // Invalidate first so a fill completing in the same cycle survives it.
        if (inv) begin
            valid_d = '0;
        end
        if (fill_done) begin
            valid_d[req_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= COMPARE;
            req_valid_q  <= 1'b0;
            req_addr_q   <= '0;
            valid_q      <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            valid_q      <= valid_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fill_done) begin
            tag_q[req_idx]  <= req_tag;
            line_q[req_idx] <= pmem_rdata;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache with a latency-programmable line memory.
module tb_icache;
    logic         clk;
    logic         rst;
    logic [31:0]  imem_address;
    logic         imem_read;
    logic [31:0]  imem_rdata;
    logic         imem_resp;
    logic         inv;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int tests_run;
    int tests_failed;
    int pm_lat;
    int pm_cnt;
    int fills;

    icache #(.S_INDEX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_address (imem_address),
        .imem_read    (imem_read),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .inv          (inv),
        .pmem_address (pmem_address),
        .pmem_read    (pmem_read),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .hit_count    (hit_count),
        .miss_count   (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hDEAD_BEEF;
    endfunction

    function automatic logic [255:0] line_data(input logic [31:0] a);
        logic [255:0] d;
        for (int w = 0; w < 8; w++) begin
            d[32*w +: 32] = ({a[31:5], 5'b0} + 32'(4 * w)) ^ 32'hDEAD_BEEF;
        end
        return d;
    endfunction

    // Line memory: answers in the pm_lat-th cycle of each read request.
    always @(negedge clk) begin
        if (pmem_read) begin
            if (pm_cnt == 0) fills = fills + 1;
            pm_cnt = pm_cnt + 1;
            if (pm_cnt == pm_lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = line_data(pmem_address);
            end else begin
                pmem_resp = 1'b0;
            end
        end else begin
            pm_cnt    = 0;
            pmem_resp = 1'b0;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; imem_read = 1'b0; inv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one request and waits for its response; cyc=0 means no response.
    task automatic do_read(input logic [31:0] a, output int cyc,
                           output logic [31:0] pa, output logic [31:0] rd);
        @(negedge clk);
        imem_address = a; imem_read = 1'b1;
        cyc = 0; pa = '0; rd = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (pmem_read && pa == 32'h0) pa = pmem_address;
            if (imem_resp) begin
                cyc = i; rd = imem_rdata;
                break;
            end
        end
        imem_read = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++; if (imem_resp !== 1'b0) begin tests_failed++; $display("FAIL reset_resp: got %0b want 0", imem_resp); end
        tests_run++; if (imem_rdata !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata: got %h want 0", imem_rdata); end
        tests_run++; if (pmem_read !== 1'b0) begin tests_failed++; $display("FAIL reset_pmem_read: got %0b want 0", pmem_read); end
        tests_run++; if (pmem_address !== 32'h0) begin tests_failed++; $display("FAIL reset_pmem_addr: got %h want 0", pmem_address); end
        tests_run++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin tests_failed++; $display("FAIL reset_counts: got %0d/%0d want 0/0", hit_count, miss_count); end
    endtask

    task automatic test_cold_miss();
        int cyc;
        int f0;
        logic [31:0] a;
        apply_reset();
        pm_lat = 3; f0 = fills;
        a = 32'h4000_0000;
        imem_address = a; imem_read = 1'b1;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (imem_resp) begin cyc = i; break; end
        end
        tests_run++; if (cyc != 5) begin tests_failed++; $display("FAIL cold_latency: got %0d want 5", cyc); end
        tests_run++; if (imem_rdata !== exp_word(a)) begin tests_failed++; $display("FAIL cold_word0: got %h want %h", imem_rdata, exp_word(a)); end
        for (int w = 1; w < 8; w++) begin
            a = 32'h4000_0000 + 32'(4 * w);
            imem_address = a;
            @(negedge clk);
            tests_run++; if (imem_resp !== 1'b1 || imem_rdata !== exp_word(a)) begin
                tests_failed++; $display("FAIL cold_word%0d: got resp=%0b %h want resp=1 %h", w, imem_resp, imem_rdata, exp_word(a));
            end
        end
        imem_read = 1'b0;
        @(negedge clk);
        tests_run++; if (hit_count !== 32'd8) begin tests_failed++; $display("FAIL cold_hits: got %0d want 8", hit_count); end
        tests_run++; if (miss_count !== 32'd1) begin tests_failed++; $display("FAIL cold_misses: got %0d want 1", miss_count); end
        tests_run++; if (fills - f0 != 1) begin tests_failed++; $display("FAIL cold_fills: got %0d want 1", fills - f0); end
    endtask

    task automatic test_idle();
        imem_read = 1'b0;
        for (int i = 0; i < 10; i++) begin
            imem_address = 32'h4000_0000 + 32'(4 * i);
            @(negedge clk);
            tests_run++; if (imem_resp !== 1'b0 || pmem_read !== 1'b0) begin
                tests_failed++; $display("FAIL idle_c%0d: got resp=%0b pmem_read=%0b want 0/0", i, imem_resp, pmem_read);
            end
        end
        tests_run++; if (hit_count !== 32'd8 || miss_count !== 32'd1) begin
            tests_failed++; $display("FAIL idle_counts: got %0d/%0d want 8/1", hit_count, miss_count);
        end
    endtask

    task automatic test_conflict();
        int cyc;
        logic [31:0] pa, rd;
        logic [31:0] seq [3];
        seq[0] = 32'h4000_0000; seq[1] = 32'h4000_0200; seq[2] = 32'h4000_0000;
        apply_reset();
        pm_lat = 1;
        for (int i = 0; i < 3; i++) begin
            do_read(seq[i], cyc, pa, rd);
            tests_run++; if (cyc != 3 || pa !== seq[i] || rd !== exp_word(seq[i])) begin
                tests_failed++; $display("FAIL conflict_%0d: got lat=%0d pa=%h rd=%h want lat=3 pa=%h rd=%h", i, cyc, pa, rd, seq[i], exp_word(seq[i]));
            end
        end
        @(negedge clk);
        tests_run++; if (miss_count !== 32'd3 || hit_count !== 32'd3) begin
            tests_failed++; $display("FAIL conflict_counts: got %0d/%0d want 3/3", hit_count, miss_count);
        end
    endtask

    task automatic test_invalidate();
        int cyc;
        logic [31:0] pa, rd;
        apply_reset();
        pm_lat = 1;
        do_read(32'h4000_0000, cyc, pa, rd);
        tests_run++; if (cyc != 3) begin tests_failed++; $display("FAIL inv_first_fill: got lat=%0d want 3", cyc); end
        do_read(32'h4000_0000, cyc, pa, rd);
        tests_run++; if (cyc != 1) begin tests_failed++; $display("FAIL inv_prehit: got lat=%0d want 1", cyc); end
        @(negedge clk); inv = 1'b1;
        @(negedge clk); inv = 1'b0;
        do_read(32'h4000_0000, cyc, pa, rd);
        tests_run++; if (cyc != 3 || pa !== 32'h4000_0000 || miss_count !== 32'd2) begin
            tests_failed++; $display("FAIL inv_refill: got lat=%0d pa=%h misses=%0d want 3 40000000 2", cyc, pa, miss_count);
        end

        pm_lat = 2;
        @(negedge clk);
        imem_address = 32'h4000_0020; imem_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests_run++; if (pmem_read !== 1'b1 || pmem_address !== 32'h4000_0020) begin
            tests_failed++; $display("FAIL inv_coinc_fill: got rd=%0b pa=%h want 1 40000020", pmem_read, pmem_address);
        end
        inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        tests_run++; if (imem_resp !== 1'b1 || imem_rdata !== exp_word(32'h4000_0020)) begin
            tests_failed++; $display("FAIL inv_coinc_resp: got resp=%0b %h want 1 %h", imem_resp, imem_rdata, exp_word(32'h4000_0020));
        end
        imem_read = 1'b0;
        do_read(32'h4000_0000, cyc, pa, rd);
        tests_run++; if (cyc != 4 || pa !== 32'h4000_0000) begin
            tests_failed++; $display("FAIL inv_coinc_other_miss: got lat=%0d pa=%h want 4 40000000", cyc, pa);
        end
        do_read(32'h4000_0020, cyc, pa, rd);
        tests_run++; if (cyc != 1 || rd !== exp_word(32'h4000_0020)) begin
            tests_failed++; $display("FAIL inv_coinc_line_hit: got lat=%0d rd=%h want 1 %h", cyc, rd, exp_word(32'h4000_0020));
        end
    endtask

    task automatic test_stall_hold();
        int cyc;
        apply_reset();
        pm_lat = 3;
        imem_address = 32'h4000_0048; imem_read = 1'b1;
        @(negedge clk);
        tests_run++; if (imem_resp !== 1'b0) begin tests_failed++; $display("FAIL stall_miss: got resp=%0b want 0", imem_resp); end
        imem_address = 32'h1234_5678;
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (pmem_read) begin
                tests_run++; if (pmem_address !== 32'h4000_0040) begin
                    tests_failed++; $display("FAIL stall_pa_c%0d: got %h want 40000040", i, pmem_address);
                end
            end
            if (imem_resp) begin cyc = i; break; end
        end
        tests_run++; if (cyc != 4 || imem_rdata !== exp_word(32'h4000_0048)) begin
            tests_failed++; $display("FAIL stall_word: got lat=%0d %h want 4 %h", cyc, imem_rdata, exp_word(32'h4000_0048));
        end
        imem_read = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        int cyc;
        int f0;
        logic [31:0] pa, rd;
        apply_reset();
        pm_lat = 5; f0 = fills;
        imem_address = 32'h4000_0100; imem_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1; imem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        tests_run++; if (imem_resp !== 1'b0 || imem_rdata !== 32'h0 || pmem_read !== 1'b0 || pmem_address !== 32'h0) begin
            tests_failed++; $display("FAIL midrst_outputs: got resp=%0b rd=%h pr=%0b pa=%h want all 0", imem_resp, imem_rdata, pmem_read, pmem_address);
        end
        tests_run++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
            tests_failed++; $display("FAIL midrst_counts: got %0d/%0d want 0/0", hit_count, miss_count);
        end
        pm_lat = 1;
        do_read(32'h4000_0100, cyc, pa, rd);
        tests_run++; if (cyc != 3 || pa !== 32'h4000_0100 || rd !== exp_word(32'h4000_0100)) begin
            tests_failed++; $display("FAIL midrst_refetch: got lat=%0d pa=%h rd=%h want 3 40000100 %h", cyc, pa, rd, exp_word(32'h4000_0100));
        end
        tests_run++; if (miss_count !== 32'd1 || fills - f0 != 2) begin
            tests_failed++; $display("FAIL midrst_fresh_miss: got misses=%0d fills=%0d want 1 2", miss_count, fills - f0);
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        pm_lat = 1; pm_cnt = 0; fills = 0;
        rst = 1'b1; inv = 1'b0; imem_read = 1'b0; imem_address = '0;
        pmem_resp = 1'b0; pmem_rdata = '0;
        test_reset();
        test_cold_miss();
        test_idle();
        test_conflict();
        test_invalidate();
        test_stall_hold();
        test_reset_mid_fill();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache: the responder side of the fetch stage's imem interface. The fetch stage presents `imem_address`/`imem_read` every cycle. This block returns `imem_rdata` with `imem_resp` one cycle later on a hit. On a miss it holds `imem_resp` low, stalling fetch, and fills the line from physical memory through a 256-bit single-beat line-read port. It also supports whole-cache invalidation and keeps hit/miss performance counters.

## Interface
Parameters:
- `S_INDEX`, default 4: index bits; 2^S_INDEX sets, 32-byte (8-word) lines.
- Derived tag width T = 27 − S_INDEX.

Ports:
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `imem_address` in 32: fetch address; bits [1:0] ignored.
- `imem_read` in 1: fetch request valid.
- `imem_rdata` out 32: instruction word for the captured request.
- `imem_resp` out 1: `imem_rdata` valid this cycle.
- `inv` in 1: invalidate all lines (fence.i).
- `pmem_address` out 32: line address {tag, index, 5'b0}.
- `pmem_read` out 1: line-read request, held until `pmem_resp`.
- `pmem_rdata` in 256: line data; word w at bits [32w+31:32w].
- `pmem_resp` in 1: single-cycle, `pmem_rdata` valid.
- `hit_count` out 32: hits since reset; wraps.
- `miss_count` out 32: misses since reset; wraps.

## Operation
- **Storage:** per set, one valid bit, a T-bit tag and a 256-bit line.
- **Address split:** tag = addr[31:5+S_INDEX], index = addr[4+S_INDEX:5], word = addr[4:2].
- **Request register** (`req_valid`, `req_addr`): loads `imem_read` and `imem_address` on a posedge when state is COMPARE and either (`req_valid`=0 or the current cycle is a hit). Otherwise it holds. The fetch stage re-presents the same address while stalled.
- **FSM states:**
  - COMPARE:
    - Hit (`req_valid` & valid[index] & tag match): `imem_resp`=1, `imem_rdata` = stored word. `hit_count`++ at the edge.
    - Miss (`req_valid` & !hit): `imem_resp`=0. Go to FILL. `miss_count`++ at the edge.
    - `req_valid`=0: `imem_resp`=0; stay.
  - FILL:
    - `pmem_read`=1, `pmem_address` = {req tag, req index, 5'b0}.
    - On `pmem_resp`: write line, tag, valid[index]=1; go to COMPARE. The retry then hits.
- **`imem_rdata`:** 0 whenever `imem_resp`=0.
- **`pmem_read`:** 0 outside FILL.
- **Invalidate:** `inv`=1 clears all valid bits at the edge.
  - In FILL with `pmem_resp` the same cycle: the fill completes and its line is valid; all other lines are cleared.
  - `inv` in FILL without `pmem_resp`: the FILL continues.
  - `inv` in COMPARE: the current-cycle hit/miss decision uses pre-clear valid bits.
- **Reset:**
  - State → COMPARE; `req_valid`=0; all valid bits 0; counters 0.
  - `imem_resp`=0, `imem_rdata`=0, `pmem_read`=0, `pmem_address`=0.
  - Reset during FILL abandons the fill; no line is written.

## Timing
- **Hit latency:** address sampled at edge N; `imem_resp` high in cycle N+1. Back-to-back hits sustain one instruction per cycle.
- **Miss timing:**
  - Cycle N+1: COMPARE miss.
  - Cycles N+2 … N+1+k: FILL, with `pmem_resp` in the k-th FILL cycle (k ≥ 1).
  - Cycle N+2+k: COMPARE hit, `imem_resp`=1.
  - Minimum miss penalty: 2 cycles beyond a hit.
- **Outputs:** `imem_resp`, `imem_rdata`, `pmem_*` are combinational from state, request register and arrays. There is no combinational path from `imem_address` to any output.
- **Address change during stall:** a new `imem_address` during a stall is ignored until the request register loads.
- **Read-after-fill:** a same-set request immediately after a fill hits only if the tags match. A tag mismatch evicts the line (direct-mapped).

## Test plan
- **Cold miss, then hits:** reset; read 0x40000000, 0x40000004 … 0x4000001C, with the pmem line returned after 3 cycles. First resp comes 5 cycles after the request edge. The following 7 words respond on consecutive cycles. `hit_count`=8, `miss_count`=1, `pmem_read` asserted exactly once.
- **Conflict eviction** (S_INDEX=4):
  - Read 0x40000000, then 0x40000200 (same index, different tag), then 0x40000000.
  - Required: three misses; `pmem_address` 0x40000000, 0x40000200, 0x40000000.
- **Invalidate:**
  - Fill 0x40000000; pulse `inv`; re-read.
  - Required: miss and refill. `inv` coincident with `pmem_resp` of a fill to 0x40000020: that line hits afterward, 0x40000000 misses.
- **Stall hold:** during FILL, drive `imem_address`=0x12345678. Required: `pmem_address` stays on the original line, and the returned word belongs to the original address.
- **Reset mid-fill:** assert `rst` in FILL cycle 2, then re-request the same address. Required: all outputs 0 the cycle after reset, a fresh miss, and a fresh `pmem_read`.
- **Idle:** `imem_read`=0 for 10 cycles. Required: `imem_resp`=0, counters unchanged, `pmem_read`=0.
